gpu_uniform_loader: RTL and testbench
=====================================

# gpu_uniform_loader

Command-stream decoder that drives the write port of the GPU uniform register file: transform matrix m00..m33 and viewport size. It consumes 32-bit command words over a valid/ready stream from the host command path. It turns them into single-cycle register writes (`we`/`addr`/`data`) for the uniforms block. It also emits a one-cycle commit pulse the pipeline uses to latch a new frame's uniforms.

## Interface
- `W`, 32, data width of command words and write data; must be ≥ 32; bits above 31 of command words are ignored; write data is zero-extended to W.

- `CLK`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command word present.
- `cmd_data`  in  W  command word (header or payload).
- `cmd_ready`  out  1  loader accepts a word this cycle; a word transfers when `cmd_valid && cmd_ready`.
- `we`  out  1  uniform write strobe, one cycle per write.
- `addr`  out  8  uniform address.
  - 0x00–0x0F: m00..m33 row-major (m00=0x00, m01=0x01, …, m33=0x0F).
  - 0x10: vp_width.
  - 0x11: vp_height.
- `data`  out  W  uniform write data; Q16.16 for matrix entries, integer for viewport.
- `commit`  out  1  one-cycle pulse on COMMIT command.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky; set by an unknown opcode; cleared only by `rst`.

## Operation
- Header layout: [31:24] opcode, [23:16] base address, [15:0] count.
- Opcodes:
  - 0x00 NOP.
  - 0x01 WRITE_REGS: `count` payload words follow.
  - 0x02 SET_VIEWPORT: one payload word, [31:16] = width, [15:0] = height.
  - 0x03 COMMIT.
  - Any other opcode is an error.
- States: IDLE, PAYLOAD, VP_DATA, VP_H.
- IDLE (`cmd_ready`=1). On transfer, decode the header:
  - NOP: stay in IDLE, no effect.
  - WRITE_REGS, count=0: stay in IDLE, no writes.
  - WRITE_REGS, count>0: ptr←base, remaining←count, go to PAYLOAD.
  - SET_VIEWPORT: go to VP_DATA. Base and count fields are ignored.
  - COMMIT: `commit`=1 next cycle, stay in IDLE.
  - Unknown opcode: `err`←1, stay in IDLE. Only the header is consumed; following words are parsed as headers.
- PAYLOAD (`cmd_ready`=1). On transfer:
  - Next cycle `we`=1, `addr`=ptr, `data`=word[31:0] zero-extended.
  - ptr←ptr+1, modulo 256 (0xFF wraps to 0x00).
  - remaining←remaining−1; when remaining was 1, go to IDLE.
- VP_DATA (`cmd_ready`=1). On transfer:
  - Next cycle `we`=1, `addr`=0x10, `data`=zero-ext word[31:16].
  - Latch word[15:0] as height, go to VP_H.
- VP_H (`cmd_ready`=0): next cycle `we`=1, `addr`=0x11, `data`=zero-ext height; go to IDLE.
- Addresses above 0x11 are issued unchanged. The uniforms block ignores them; they do not set `err`.
- Idle cycles with `cmd_valid`=0 stall any state except VP_H, with no outputs changing.
- `cmd_ready` is a function of state only and never depends on `cmd_valid`.

## Timing
- Reset values:
  - state = IDLE.
  - `we`=0, `addr`=0x00, `data`=0.
  - `commit`=0, `busy`=0, `err`=0.
  - `cmd_ready`=1 in the first cycle after reset.
  - ptr=0, remaining=0.
- Write latency: payload accepted at edge t produces `we`/`addr`/`data` registered valid for exactly the cycle after t.
- `we` and `commit` are one-cycle pulses. `addr`/`data` hold their last value while `we`=0.
- WRITE_REGS sustains one write per cycle with back-to-back valid.
- A new header is accepted in the cycle after the last payload word. No bubble is required.
- SET_VIEWPORT: two consecutive `we` cycles; `cmd_ready`=0 for exactly one cycle (VP_H).
- `busy` is 1 from the cycle after header acceptance until the state returns to IDLE.
- `rst` asserted mid-command: the next cycle is IDLE with all outputs at reset values.
  - A pending VP_H write is dropped.
  - The remaining payload is abandoned; later words are parsed as headers.
  - `rst` overrides a simultaneous transfer.
- `err` set and a COMMIT can never coincide, since only one header decodes per cycle.

## Test plan
- Reset → `we`=0, `commit`=0, `busy`=0, `err`=0, `cmd_ready`=1, `addr`=0x00, `data`=0.
- WRITE_REGS: header 0x01000004, then 0x00020000, 0x00000001, 0x00000002, 0x00010000 back-to-back.
  - → `we` high 4 consecutive cycles, each 1 cycle after acceptance.
  - → (addr, data) = (0x00, 0x00020000), (0x01, 1), (0x02, 2), (0x03, 0x00010000).
  - → `busy` falls after the last write; stalled `cmd_valid` gaps insert matching `we` gaps.
- SET_VIEWPORT: header 0x02000000, then payload 0x028001E0.
  - → (0x10, 640) then (0x11, 480) on consecutive cycles.
  - → `cmd_ready`=0 for exactly the VP_H cycle.
- Wrap and empty: header 0x01FF0002 plus two words → addr 0xFF then 0x00. Header 0x01050000 → no `we`, `busy` stays 0.
- Error and commit:
  - Header 0x7F000003 → `err`=1 and stays 1, no `we`.
  - Following 0x03000000 → `commit` pulses for one cycle; no `we`, `err` stays 1.
- Reset mid-payload:
  - 0x01000004 + 2 words, then `rst` for 1 cycle → IDLE, `busy`=0, no further `we`.
  - Next 0x01100001 + 0x00000140 → single write (0x10, 320).

Source files
------------

// File: rtl/gpu_uniform_loader_if.sv
// Command stream in, uniform register-file write port out, plus commit/status.
// The host side holds the master modport; the loader holds the slave modport.
interface gpu_uniform_loader_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic [W-1:0] cmd_data;
  logic         cmd_ready;
  logic         we;
  logic [7:0]   addr;
  logic [W-1:0] data;
  logic         commit;
  logic         busy;
  logic         err;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, we, addr, data, commit, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, we, addr, data, commit, busy, err
  );
endinterface

// File: rtl/gpu_uniform_loader.sv
// Decodes 32-bit command words into single-cycle uniform register writes
// (matrix m00..m33 and viewport size) and a one-cycle frame commit pulse.
module gpu_uniform_loader #(
  parameter int W = 32
) (
  input  logic                 CLK,
  input  logic                 rst,
  gpu_uniform_loader_if.slave  bus
);

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_WRITE_REGS   = 8'h01;
  localparam logic [7:0] OP_SET_VIEWPORT = 8'h02;
  localparam logic [7:0] OP_COMMIT       = 8'h03;

  localparam logic [7:0] ADDR_VP_WIDTH   = 8'h10;
  localparam logic [7:0] ADDR_VP_HEIGHT  = 8'h11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_VP_DATA,
    S_VP_H
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   ptr_q, ptr_d;
  logic [15:0]  remaining_q, remaining_d;
  logic [15:0]  height_q, height_d;
  logic         we_q, we_d;
  logic [7:0]   addr_q, addr_d;
  logic [W-1:0] data_q, data_d;
  logic         commit_q, commit_d;
  logic         err_q, err_d;

  logic [31:0]  cmd_word;
  logic [7:0]   hdr_opcode;
  logic [7:0]   hdr_base;
  logic [15:0]  hdr_count;
  logic         cmd_ready;
  logic         xfer;

  // Only the low 32 bits of a command word carry meaning.
  assign cmd_word   = bus.cmd_data[31:0];
  assign hdr_opcode = cmd_word[31:24];
  assign hdr_base   = cmd_word[23:16];
  assign hdr_count  = cmd_word[15:0];

  // The VP_H cycle issues the height write without consuming a word.
  assign cmd_ready = (state_q != S_VP_H);
  assign xfer      = bus.cmd_valid && cmd_ready;

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    height_d    = height_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    commit_d    = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          case (hdr_opcode)
            OP_NOP: ;
            OP_WRITE_REGS: begin
              if (hdr_count != 16'd0) begin
                ptr_d       = hdr_base;
                remaining_d = hdr_count;
                state_d     = S_PAYLOAD;
              end
            end
            OP_SET_VIEWPORT: state_d = S_VP_DATA;
            OP_COMMIT:       commit_d = 1'b1;
            default:         err_d = 1'b1;
          endcase
        end
      end

      S_PAYLOAD: begin
        if (xfer) begin
          we_d        = 1'b1;
          addr_d      = ptr_q;
          data_d      = W'(cmd_word);
          ptr_d       = ptr_q + 8'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = S_IDLE;
        end
      end

      S_VP_DATA: begin
        if (xfer) begin
          we_d     = 1'b1;
          addr_d   = ADDR_VP_WIDTH;
          data_d   = W'(cmd_word[31:16]);
          height_d = cmd_word[15:0];
          state_d  = S_VP_H;
        end
      end

      S_VP_H: begin
        we_d    = 1'b1;
        addr_d  = ADDR_VP_HEIGHT;
        data_d  = W'(height_q);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 8'h00;
      remaining_q <= 16'h0000;
      height_q    <= 16'h0000;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= '0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      height_q    <= height_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.commit    = commit_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_gpu_uniform_loader.sv
// Directed bench for gpu_uniform_loader: inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_gpu_uniform_loader;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  gpu_uniform_loader_if #(.W(32)) bus ();

  gpu_uniform_loader #(.W(32)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (bus.we !== 1'b0 || bus.commit !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 ||
          bus.cmd_ready !== 1'b1 || bus.addr !== 8'h00 || bus.data !== 32'h0)
        $display("FAIL reset[%0d]: we=%b commit=%b busy=%b err=%b ready=%b addr=%h data=%h expected 0 0 0 0 1 00 00000000",
                 i, bus.we, bus.commit, bus.busy, bus.err, bus.cmd_ready, bus.addr, bus.data);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_write_regs();
    logic [31:0] words [4] = '{32'h00020000, 32'h00000001, 32'h00000002, 32'h00010000};
    logic [31:0] gw    [3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    drive(1'b1, 32'h01000004);
    step();
    total_cnt++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL wr_header: we=%b busy=%b expected we=0 busy=1", bus.we, bus.busy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i]);
      step();
      total_cnt++;
      if (bus.we !== 1'b1 || bus.addr !== 8'(i) || bus.data !== words[i] || bus.busy !== (i != 3))
        $display("FAIL wr_word[%0d]: we=%b addr=%h data=%h busy=%b expected we=1 addr=%h data=%h busy=%b",
                 i, bus.we, bus.addr, bus.data, bus.busy, 8'(i), words[i], (i != 3));
      else pass_cnt++;
    end
    drive(1'b0, 32'h0);
    step();
    total_cnt++;
    if (bus.we !== 1'b0 || bus.addr !== 8'h03 || bus.data !== 32'h00010000)
      $display("FAIL wr_hold: we=%b addr=%h data=%h expected we=0 addr=03 data=00010000",
               bus.we, bus.addr, bus.data);
    else pass_cnt++;
    // Stalled stream into a base above the uniform map: gaps give matching we gaps.
    drive(1'b1, 32'h01200003);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, gw[i]);
      step();
      total_cnt++;
      if (bus.we !== 1'b1 || bus.addr !== 8'(8'h20 + i) || bus.data !== gw[i] || bus.err !== 1'b0)
        $display("FAIL stall_word[%0d]: we=%b addr=%h data=%h err=%b expected we=1 addr=%h data=%h err=0",
                 i, bus.we, bus.addr, bus.data, bus.err, 8'(8'h20 + i), gw[i]);
      else pass_cnt++;
      drive(1'b0, 32'hFFFF_FFFF);
      step();
      total_cnt++;
      if (bus.we !== 1'b0 || bus.addr !== 8'(8'h20 + i) || bus.data !== gw[i] || bus.busy !== (i != 2))
        $display("FAIL stall_gap[%0d]: we=%b addr=%h data=%h busy=%b expected we=0 addr=%h data=%h busy=%b",
                 i, bus.we, bus.addr, bus.data, bus.busy, 8'(8'h20 + i), gw[i], (i != 2));
      else pass_cnt++;
    end
  endtask

  task automatic test_viewport();
    drive(1'b1, 32'h02000000);
    step();
    total_cnt++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b1)
      $display("FAIL vp_header: we=%b busy=%b ready=%b expected 0 1 1", bus.we, bus.busy, bus.cmd_ready);
    else pass_cnt++;
    drive(1'b1, 32'h028001E0);
    step();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.addr !== 8'h10 || bus.data !== 32'd640 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL vp_width: we=%b addr=%h data=%0d ready=%b busy=%b expected we=1 addr=10 data=640 ready=0 busy=1",
               bus.we, bus.addr, bus.data, bus.cmd_ready, bus.busy);
    else pass_cnt++;
    // A COMMIT held during VP_H must wait one cycle before being taken.
    drive(1'b1, 32'h03000000);
    step();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.addr !== 8'h11 || bus.data !== 32'd480 || bus.cmd_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.commit !== 1'b0)
      $display("FAIL vp_height: we=%b addr=%h data=%0d ready=%b busy=%b commit=%b expected we=1 addr=11 data=480 ready=1 busy=0 commit=0",
               bus.we, bus.addr, bus.data, bus.cmd_ready, bus.busy, bus.commit);
    else pass_cnt++;
    step();
    drive(1'b0, 32'h0);
    total_cnt++;
    if (bus.commit !== 1'b1 || bus.we !== 1'b0)
      $display("FAIL vp_commit: commit=%b we=%b expected commit=1 we=0", bus.commit, bus.we);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.commit !== 1'b0)
      $display("FAIL vp_commit_pulse: commit=%b expected 0", bus.commit);
    else pass_cnt++;
  endtask

  task automatic test_wrap_empty();
    drive(1'b1, 32'h01FF0002);
    step();
    drive(1'b1, 32'h0000AAAA);
    step();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.addr !== 8'hFF || bus.data !== 32'h0000AAAA)
      $display("FAIL wrap_ff: we=%b addr=%h data=%h expected we=1 addr=ff data=0000aaaa", bus.we, bus.addr, bus.data);
    else pass_cnt++;
    drive(1'b1, 32'h0000BBBB);
    step();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.addr !== 8'h00 || bus.data !== 32'h0000BBBB || bus.busy !== 1'b0)
      $display("FAIL wrap_00: we=%b addr=%h data=%h busy=%b expected we=1 addr=00 data=0000bbbb busy=0",
               bus.we, bus.addr, bus.data, bus.busy);
    else pass_cnt++;
    drive(1'b1, 32'h01050000);
    step();
    drive(1'b0, 32'h0);
    total_cnt++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.addr !== 8'h00)
      $display("FAIL empty_write: we=%b busy=%b addr=%h expected we=0 busy=0 addr=00", bus.we, bus.busy, bus.addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL empty_after: we=%b busy=%b expected 0 0", bus.we, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4] = '{32'h01400001, 32'h12345678, 32'h01410001, 32'h9ABCDEF0};
    logic        ewe [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  ea  [4] = '{8'h00, 8'h40, 8'h40, 8'h41};
    logic [31:0] ed  [4] = '{32'h0000BBBB, 32'h12345678, 32'h12345678, 32'h9ABCDEF0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i]);
      step();
      total_cnt++;
      if (bus.we !== ewe[i] || bus.addr !== ea[i] || bus.data !== ed[i])
        $display("FAIL b2b[%0d]: we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                 i, bus.we, bus.addr, bus.data, ewe[i], ea[i], ed[i]);
      else pass_cnt++;
    end
    drive(1'b0, 32'h0);
    step();
  endtask

  task automatic test_err_commit();
    drive(1'b1, 32'h7F000003);
    step();
    total_cnt++;
    if (bus.err !== 1'b1 || bus.we !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL err_set: err=%b we=%b busy=%b expected err=1 we=0 busy=0", bus.err, bus.we, bus.busy);
    else pass_cnt++;
    drive(1'b1, 32'h03000000);
    step();
    drive(1'b0, 32'h0);
    total_cnt++;
    if (bus.commit !== 1'b1 || bus.err !== 1'b1 || bus.we !== 1'b0)
      $display("FAIL err_commit: commit=%b err=%b we=%b expected commit=1 err=1 we=0", bus.commit, bus.err, bus.we);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.commit !== 1'b0 || bus.err !== 1'b1)
      $display("FAIL err_sticky: commit=%b err=%b expected commit=0 err=1", bus.commit, bus.err);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_payload();
    drive(1'b1, 32'h01000004);
    step();
    drive(1'b1, 32'h00000011);
    step();
    drive(1'b1, 32'h00000022);
    step();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.addr !== 8'h01 || bus.data !== 32'h00000022)
      $display("FAIL rst_pre: we=%b addr=%h data=%h expected we=1 addr=01 data=00000022", bus.we, bus.addr, bus.data);
    else pass_cnt++;
    rst = 1'b1;
    drive(1'b1, 32'h00000033);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    total_cnt++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.addr !== 8'h00 || bus.data !== 32'h0 || bus.commit !== 1'b0)
      $display("FAIL rst_mid: we=%b busy=%b err=%b ready=%b addr=%h data=%h commit=%b expected 0 0 0 1 00 00000000 0",
               bus.we, bus.busy, bus.err, bus.cmd_ready, bus.addr, bus.data, bus.commit);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rst_idle: we=%b busy=%b expected 0 0", bus.we, bus.busy);
    else pass_cnt++;
    drive(1'b1, 32'h01100001);
    step();
    drive(1'b1, 32'h00000140);
    step();
    drive(1'b0, 32'h0);
    total_cnt++;
    if (bus.we !== 1'b1 || bus.addr !== 8'h10 || bus.data !== 32'd320 || bus.busy !== 1'b0)
      $display("FAIL rst_rewrite: we=%b addr=%h data=%0d busy=%b expected we=1 addr=10 data=320 busy=0",
               bus.we, bus.addr, bus.data, bus.busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.we !== 1'b0 || bus.addr !== 8'h10)
      $display("FAIL rst_single: we=%b addr=%h expected we=0 addr=10", bus.we, bus.addr);
    else pass_cnt++;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    test_reset();
    test_write_regs();
    test_viewport();
    test_wrap_empty();
    test_back_to_back();
    test_err_commit();
    test_rst_mid_payload();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
